// File: rtl/vec_pkg.sv
// Shared types and constants for the vector recorder: word layout
// {d, clk, q}, default sizes and the recorder state encoding.
package vec_pkg;

    localparam int VEC_DW    = 4;
    localparam int VEC_W     = 2 * VEC_DW + 1;
    localparam int VEC_DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READOUT = 2'd2
    } rec_state_t;

    // Builds one vector word in the same bit order the flip-flop bench reads.
    function automatic logic [VEC_W-1:0] pack_vec(input logic [VEC_DW-1:0] d,
                                                  input logic              clk,
                                                  input logic [VEC_DW-1:0] q);
        return {d, clk, q};
    endfunction

endpackage

// File: rtl/vec_ram.sv
// Vector storage: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; only the pointers are.
module vec_ram #(
    parameter int DEPTH = 32,
    parameter int W     = 9
) (
    input  logic                     clkSimulation,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Store one word per enabled write cycle.
    always_ff @(posedge clkSimulation) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vector_recorder.sv
// Capture buffer for flip-flop test vectors {d, clk_in, q}: records up to
// DEPTH samples in a capture window, then plays them back over valid/ready.
//
// state   | meaning
// IDLE    | waiting for start; count of the last capture stays readable
// CAPTURE | window open, sample_en writes one word per cycle
// READOUT | stored words presented on rd_data, one per accepted transfer
module vector_recorder
    import vec_pkg::*;
#(
    parameter int DEPTH = VEC_DEPTH,
    parameter int DW    = VEC_DW
) (
    input  logic                   clkSimulation,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   sample_en,
    input  logic [DW-1:0]          d,
    input  logic                   clk_in,
    input  logic [DW-1:0]          q,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [2*DW:0]          rd_data,
    output logic                   rd_last,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   full,
    output logic                   dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int W  = 2 * DW + 1;

    rec_state_t    state, state_nx;
    logic [AW-1:0] wr_ptr, wr_ptr_nx;
    logic [AW-1:0] rd_ptr, rd_ptr_nx;
    logic [CW-1:0] count_q, count_nx;
    logic          dropped_q, dropped_nx;
    logic          we;
    logic          last_w;
    logic [W-1:0]  ram_rdata;

    vec_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
        .clkSimulation (clkSimulation),
        .we            (we),
        .waddr         (wr_ptr),
        .wdata         ({d, clk_in, q}),
        .raddr         (rd_ptr),
        .rdata         (ram_rdata)
    );

    // Compared against count-1 so the final word is flagged while it is presented.
    assign last_w = (state == READOUT) && ({1'b0, rd_ptr} == (count_q - CW'(1)));

    // State, pointer, count and sticky-flag registers with synchronous active-low reset.
    always_ff @(posedge clkSimulation) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            state     <= state_nx;
            wr_ptr    <= wr_ptr_nx;
            rd_ptr    <= rd_ptr_nx;
            count_q   <= count_nx;
            dropped_q <= dropped_nx;
        end
    end

    // Next-state, pointer updates and write enable.
    always_comb begin
        state_nx   = state;
        wr_ptr_nx  = wr_ptr;
        rd_ptr_nx  = rd_ptr;
        count_nx   = count_q;
        dropped_nx = dropped_q;
        we         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = CAPTURE;
                    wr_ptr_nx  = '0;
                    rd_ptr_nx  = '0;
                    count_nx   = '0;
                    dropped_nx = 1'b0;
                end else if (sample_en) begin
                    dropped_nx = 1'b1;
                end
            end
            CAPTURE: begin
                // A restart wins over any same-cycle sample or stop.
                if (start) begin
                    wr_ptr_nx = '0;
                    rd_ptr_nx = '0;
                    count_nx  = '0;
                end else begin
                    if (sample_en) begin
                        we        = 1'b1;
                        wr_ptr_nx = wr_ptr + AW'(1);
                        count_nx  = count_q + CW'(1);
                    end
                    if (sample_en && (count_q == CW'(DEPTH - 1))) begin
                        state_nx = READOUT;
                    end else if (stop) begin
                        state_nx = (sample_en || (count_q != '0)) ? READOUT : IDLE;
                    end
                end
            end
            READOUT: begin
                if (sample_en) begin
                    dropped_nx = 1'b1;
                end
                if (rd_ready) begin
                    rd_ptr_nx = rd_ptr + AW'(1);
                    if (last_w) begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rd_valid = (state == READOUT);
    assign rd_data  = rd_valid ? ram_rdata : '0;
    assign rd_last  = last_w;
    assign count    = count_q;
    assign busy     = (state != IDLE);
    assign full     = (count_q == CW'(DEPTH));
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_vector_recorder.sv
// Self-checking bench for vector_recorder: directed test-plan sequences with
// literal expectations, then randomized stimulus, all compared every cycle
// against a queue-based behavioural model.
module tb_vector_recorder;

    localparam int DEPTH = 32;
    localparam int DW    = 4;

    logic       clkSimulation = 1'b0;
    logic       rst = 1'b0, start = 1'b0, stop = 1'b0, sample_en = 1'b0;
    logic       clk_in = 1'b0, rd_ready = 1'b0;
    logic [3:0] d = '0, q = '0;
    logic       rd_valid, rd_last, busy, full, dropped;
    logic [8:0] rd_data;
    logic [5:0] count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    vector_recorder #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clkSimulation (clkSimulation),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .sample_en     (sample_en),
        .d             (d),
        .clk_in        (clk_in),
        .q             (q),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_last       (rd_last),
        .count         (count),
        .busy          (busy),
        .full          (full),
        .dropped       (dropped)
    );

    always #5 clkSimulation = ~clkSimulation;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = idle, 1 = capturing, 2 = reading out.
    int         m_mode = 0;
    logic [8:0] m_words[$];
    int         m_rd = 0;
    bit         m_drop = 1'b0;

    // Readout log and valid watch, taken from the DUT at each edge.
    logic [8:0] got[$];
    bit         got_last[$];
    bit         saw_valid = 1'b0;

    always @(posedge clkSimulation) begin
        if (rd_valid) saw_valid = 1'b1;
        if (rd_valid && rd_ready) begin
            got.push_back(rd_data);
            got_last.push_back(rd_last);
        end
        if (!rst) begin
            m_mode = 0; m_words.delete(); m_rd = 0; m_drop = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    if (start) begin
                        m_mode = 1; m_words.delete(); m_rd = 0; m_drop = 1'b0;
                    end else if (sample_en) begin
                        m_drop = 1'b1;
                    end
                end
                1: begin
                    if (start) begin
                        m_words.delete(); m_rd = 0;
                    end else begin
                        if (sample_en) m_words.push_back({d, clk_in, q});
                        if (m_words.size() == DEPTH) m_mode = 2;
                        else if (stop) m_mode = (m_words.size() > 0) ? 2 : 0;
                    end
                end
                default: begin
                    if (sample_en) m_drop = 1'b1;
                    if (rd_ready) begin
                        if (m_rd == m_words.size() - 1) m_mode = 0;
                        m_rd++;
                    end
                end
            endcase
        end
    end

    // Compare every output against the model each cycle, away from the active edge.
    always @(negedge clkSimulation) begin
        if (chk_en) begin
            logic       e_valid;
            logic [8:0] e_data;
            e_valid = (m_mode == 2);
            e_data  = e_valid ? m_words[m_rd] : 9'd0;
            check("rd_valid", rd_valid, e_valid);
            check("rd_data", rd_data, e_data);
            check("rd_last", rd_last, e_valid && (m_rd == m_words.size() - 1));
            check("count", count, m_words.size());
            check("busy", busy, m_mode != 0);
            check("full", full, m_words.size() == DEPTH);
            check("dropped", dropped, m_drop);
        end
    end

    task automatic idle_in();
        start = 1'b0; stop = 1'b0; sample_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clkSimulation); idle_in();
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clkSimulation); idle_in();
    endtask

    task automatic sample(input logic [3:0] dv, input logic cv, input logic [3:0] qv);
        sample_en = 1'b1; d = dv; clk_in = cv; q = qv;
        @(negedge clkSimulation);
        idle_in();
    endtask

    task automatic pulse_reset();
        rst = 1'b0; idle_in(); @(negedge clkSimulation); rst = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clkSimulation);
            n++;
        end
        check("wait_idle_timeout", busy, 1'b0);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_last"}, rd_last, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_dropped"}, dropped, 0);
    endtask

    initial begin
        logic [3:0] iv;
        rst = 1'b0;
        repeat (2) @(negedge clkSimulation);
        rst = 1'b1;
        chk_en = 1'b1;
        check_all_zero("reset");

        // Test 1: three samples, stop, drain with rd_ready high.
        rd_ready = 1'b1;
        got.delete(); got_last.delete();
        pulse_start();
        sample(4'hA, 1'b1, 4'h5);
        sample(4'h3, 1'b0, 4'h3);
        sample(4'hF, 1'b1, 4'h0);
        check("t1_count", count, 3);
        pulse_stop();
        wait_idle(20);
        check("t1_nwords", got.size(), 3);
        if (got.size() == 3) begin
            check("t1_w0", got[0], 9'b1010_1_0101);
            check("t1_w1", got[1], 9'b0011_0_0011);
            check("t1_w2", got[2], 9'b1111_1_0000);
            check("t1_last", {got_last[0], got_last[1], got_last[2]}, 3'b001);
        end
        check("t1_busy", busy, 0);
        check("t1_count_held", count, 3);

        // Tests 2 and 3: fill to DEPTH, auto readout, stall pattern 1,0,0,1.
        rd_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            iv = i[3:0];
            sample(iv, iv[0], ~iv);
        end
        check("t2_full", full, 1);
        check("t2_valid", rd_valid, 1);
        got.delete(); got_last.delete();
        rd_ready = 1'b1; @(negedge clkSimulation);
        rd_ready = 1'b0;
        check("t3_stall1", rd_data, 9'b0001_1_1110);
        @(negedge clkSimulation);
        check("t3_stall2", rd_data, 9'b0001_1_1110);
        check("t3_stall_last", rd_last, 0);
        rd_ready = 1'b1;
        wait_idle(60);
        check("t2_nwords", got.size(), DEPTH);
        for (int i = 0; i < got.size(); i++) begin
            iv = i[3:0];
            check("t2_word", got[i], {iv, iv[0], ~iv});
        end
        check("t2_dropped", dropped, 0);

        // Test 4: start then stop with nothing stored.
        saw_valid = 1'b0;
        pulse_start();
        pulse_stop();
        @(negedge clkSimulation);
        check("t4_busy", busy, 0);
        check("t4_count", count, 0);
        check("t4_no_valid", saw_valid, 0);

        // Test 5: dropped samples in IDLE and READOUT.
        sample(4'h1, 1'b0, 4'h1);
        check("t5_drop_idle", dropped, 1);
        pulse_start();
        check("t5_drop_cleared", dropped, 0);
        sample(4'h6, 1'b1, 4'h9);
        sample(4'hC, 1'b0, 4'h2);
        rd_ready = 1'b0;
        pulse_stop();
        sample(4'hE, 1'b1, 4'hE);
        check("t5_drop_read", dropped, 1);
        check("t5_count", count, 2);
        got.delete(); got_last.delete();
        rd_ready = 1'b1;
        wait_idle(20);
        check("t5_nwords", got.size(), 2);
        if (got.size() == 2) begin
            check("t5_w0", got[0], 9'b0110_1_1001);
            check("t5_w1", got[1], 9'b1100_0_0010);
        end
        check("t5_drop_sticky", dropped, 1);
        pulse_start();
        check("t5_drop_start", dropped, 0);
        pulse_stop();

        // Test 6a: reset mid-capture.
        pulse_start();
        for (int i = 0; i < 5; i++) sample(4'h8, 1'b1, 4'h8);
        pulse_reset();
        check_all_zero("t6a");
        got.delete(); got_last.delete();
        pulse_start();
        sample(4'h7, 1'b1, 4'h2);
        pulse_stop();
        wait_idle(20);
        check("t6a_nwords", got.size(), 1);
        if (got.size() == 1) check("t6a_w0", got[0], 9'b0111_1_0010);

        // Test 6b: reset after two readout transfers.
        rd_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) sample(4'h4, 1'b0, 4'h4);
        pulse_stop();
        rd_ready = 1'b1;
        repeat (2) @(negedge clkSimulation);
        rd_ready = 1'b0;
        pulse_reset();
        check_all_zero("t6b");
        got.delete(); got_last.delete();
        rd_ready = 1'b1;
        pulse_start();
        sample(4'h2, 1'b0, 4'hD);
        pulse_stop();
        wait_idle(20);
        check("t6b_nwords", got.size(), 1);
        if (got.size() == 1) check("t6b_w0", got[0], 9'b0010_0_1101);

        // Randomized phase: model comparison runs every cycle.
        for (int n = 0; n < 1500; n++) begin
            rst       = ($urandom_range(0, 99) != 0);
            start     = ($urandom_range(0, 29) == 0);
            stop      = ($urandom_range(0, 19) == 0);
            sample_en = ($urandom_range(0, 2) != 0);
            rd_ready  = ($urandom_range(0, 2) != 0);
            d         = 4'($urandom);
            q         = 4'($urandom);
            clk_in    = 1'($urandom);
            @(negedge clkSimulation);
        end
        rst = 1'b1; idle_in(); rd_ready = 1'b1;
        wait_idle(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
